// File: rtl/htif_mailbox.sv
// Host-interface mailbox: snoops SRAM writes for the ARG/CMD word pair, queues
// putchar bytes in a small FIFO drained over valid/ready, and latches exit status.
module htif_mailbox #(
  parameter logic [13:0] ARG_ADDR   = 14'h400,
  parameter logic [13:0] CMD_ADDR   = 14'h401,
  parameter logic [31:0] CMD_PUTC   = 32'h01010000,
  parameter logic [31:0] CMD_EXIT   = 32'h00000000,
  parameter int          FIFO_DEPTH = 8,
  localparam int         PTR_W      = $clog2(FIFO_DEPTH),
  localparam int         LVL_W      = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             we,
  input  logic [13:0]      a,
  input  logic [31:0]      di,
  output logic             char_vld,
  output logic [7:0]       char_data,
  input  logic             char_rdy,
  output logic             done,
  output logic [31:0]      exit_code,
  output logic [7:0]       drop_cnt,
  output logic [LVL_W-1:0] fifo_level
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_arg;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0] r_count;
  logic [7:0]       r_last;
  logic             r_done;
  logic [31:0]      r_exit_code;
  logic [7:0]       r_drop_cnt;

  logic w_arg_hit, w_cmd_hit;
  logic w_arg_ld, w_push_req, w_push, w_pop, w_drop, w_exit, w_full, w_empty;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_arg_hit = cs & we & (a == ARG_ADDR);
  assign w_cmd_hit = cs & we & (a == CMD_ADDR);
  assign w_full    = (r_count == LVL_W'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_arg_ld    = 1'b0;
    w_push_req  = 1'b0;
    w_drop      = 1'b0;
    w_exit      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arg_hit) begin
          w_arg_ld    = 1'b1;
          w_state_nxt = S_ARMED;
        end else if (w_cmd_hit) begin
          w_drop = 1'b1;
        end
      end
      S_ARMED: begin
        if (w_arg_hit) begin
          w_arg_ld = 1'b1;
        end else if (w_cmd_hit) begin
          if (di == CMD_PUTC) begin
            w_push_req  = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (di == CMD_EXIT) begin
            w_exit      = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_drop      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Full is judged on the registered level, so a same-cycle pop never rescues a push.
  assign w_push = w_push_req & ~w_full;
  assign w_pop  = ~w_empty & char_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last      <= 8'h00;
      r_done      <= 1'b0;
      r_exit_code <= 32'h0;
      r_drop_cnt  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + LVL_W'(w_push) - LVL_W'(w_pop);
      if (w_exit) begin
        r_done      <= 1'b1;
        r_exit_code <= r_arg;
      end
      if (w_drop | (w_push_req & w_full)) r_drop_cnt <= sat_inc8(r_drop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (w_arg_ld) r_arg <= di;
    if (w_push)   r_mem[r_wr_ptr] <= r_arg[7:0];
  end

  // Once the head is popped and the FIFO runs dry, the last delivered byte is held.
  assign char_vld   = ~w_empty;
  assign char_data  = w_empty ? r_last : r_mem[r_rd_ptr];
  assign done       = r_done;
  assign exit_code  = r_exit_code;
  assign drop_cnt   = r_drop_cnt;
  assign fifo_level = r_count;

endmodule

// File: tb/tb_htif_mailbox.sv
// Bench for htif_mailbox: directed scenarios plus a randomized run, all checked
// against a queue-based behavioural model of the mailbox protocol.
module tb_htif_mailbox;

  localparam logic [13:0] ARG  = 14'h400;
  localparam logic [13:0] CMD  = 14'h401;
  localparam logic [31:0] PUTC = 32'h01010000;
  localparam logic [31:0] EXIT = 32'h00000000;
  localparam int          DEPTH = 8;

  logic        clk, rst, cs, we, char_rdy;
  logic [13:0] a;
  logic [31:0] di;
  logic        char_vld, done;
  logic [7:0]  char_data, drop_cnt;
  logic [31:0] exit_code;
  logic [3:0]  fifo_level;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [7:0]  m_q[$];
  logic        m_armed = 1'b0;
  logic        m_done  = 1'b0;
  logic [31:0] m_arg   = 32'h0;
  logic [31:0] m_exit  = 32'h0;
  int          m_drop  = 0;
  logic [7:0]  m_last  = 8'h00;

  htif_mailbox dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .a(a), .di(di),
    .char_vld(char_vld), .char_data(char_data), .char_rdy(char_rdy),
    .done(done), .exit_code(exit_code), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step();
    bit full;
    if (rst) begin
      m_q.delete();
      m_armed = 1'b0;
      m_done  = 1'b0;
      m_exit  = 32'h0;
      m_drop  = 0;
      m_last  = 8'h00;
    end else begin
      full = (m_q.size() == DEPTH);
      if (m_q.size() > 0 && char_rdy) m_last = m_q.pop_front();
      if (cs && we && !m_done) begin
        if (a == ARG) begin
          m_arg   = di;
          m_armed = 1'b1;
        end else if (a == CMD) begin
          if (!m_armed) m_drop = m_drop + 1;
          else begin
            m_armed = 1'b0;
            if (di == PUTC) begin
              if (!full) m_q.push_back(m_arg[7:0]);
              else m_drop = m_drop + 1;
            end else if (di == EXIT) begin
              m_done = 1'b1;
              m_exit = m_arg;
            end else m_drop = m_drop + 1;
          end
        end
      end
      if (m_drop > 255) m_drop = 255;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [13:0] addr, input logic [31:0] data);
    cs = 1'b1; we = 1'b1; a = addr; di = data;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    total++; if (char_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0h want=0", char_vld); end
    total++; if (char_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h want=0", char_data); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0h want=0", done); end
    total++; if (exit_code !== 32'h0) begin bad++; $display("FAIL reset_exit got=%0h want=0", exit_code); end
    total++; if (drop_cnt !== 8'h0) begin bad++; $display("FAIL reset_drop got=%0h want=0", drop_cnt); end
    total++; if (fifo_level !== 4'h0) begin bad++; $display("FAIL reset_level got=%0h want=0", fifo_level); end
  endtask

  task automatic test_putc_single();
    do_reset();
    char_rdy = 1'b1;
    wr(ARG, 32'h41);
    wr(CMD, PUTC);
    total++; if (char_vld !== 1'b1) begin bad++; $display("FAIL putc_vld got=%0h want=1", char_vld); end
    total++; if (char_data !== 8'h41) begin bad++; $display("FAIL putc_data got=%0h want=41", char_data); end
    total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL putc_level got=%0d want=1", fifo_level); end
    tick();
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL putc_drained got=%0d want=0", fifo_level); end
    total++; if (char_data !== 8'h41) begin bad++; $display("FAIL putc_hold got=%0h want=41", char_data); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL putc_drop got=%0d want=0", drop_cnt); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    char_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr(ARG, 32'h30 + i);
      wr(CMD, PUTC);
    end
    total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL full_level got=%0d want=8", fifo_level); end
    total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL full_drop got=%0d want=2", drop_cnt); end
    char_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (char_vld !== 1'b1 || char_data !== 8'(8'h30 + i)) begin
        bad++; $display("FAIL drain_%0d got vld=%0h data=%0h want vld=1 data=%0h", i, char_vld, char_data, 8'h30 + i);
      end
      tick();
    end
    total++; if (fifo_level !== 4'd0 || char_vld !== 1'b0) begin bad++; $display("FAIL drain_empty got level=%0d vld=%0h want 0/0", fifo_level, char_vld); end
  endtask

  task automatic test_orphan();
    do_reset();
    char_rdy = 1'b1;
    wr(CMD, PUTC);
    wr(ARG, 32'h1);
    wr(CMD, 32'hDEADBEEF);
    total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL orphan_drop got=%0d want=2", drop_cnt); end
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL orphan_level got=%0d want=0", fifo_level); end
    wr(CMD, PUTC);
    total++; if (drop_cnt !== 8'd3) begin bad++; $display("FAIL orphan_idle got=%0d want=3", drop_cnt); end
  endtask

  task automatic test_exit();
    do_reset();
    wr(ARG, 32'h5);
    wr(ARG, 32'h7);
    wr(CMD, EXIT);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL exit_done got=%0h want=1", done); end
    total++; if (exit_code !== 32'h7) begin bad++; $display("FAIL exit_code got=%0h want=7", exit_code); end
    wr(ARG, 32'h55);
    wr(CMD, PUTC);
    wr(CMD, 32'h1234);
    tick();
    total++; if (drop_cnt !== 8'd0 || fifo_level !== 4'd0) begin bad++; $display("FAIL exit_ignore got drop=%0d level=%0d want 0/0", drop_cnt, fifo_level); end
    total++; if (done !== 1'b1 || exit_code !== 32'h7) begin bad++; $display("FAIL exit_sticky got done=%0h code=%0h want 1/7", done, exit_code); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    char_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr(ARG, 32'h61 + i);
      wr(CMD, PUTC);
    end
    wr(ARG, 32'h99);
    total++; if (fifo_level !== 4'd3) begin bad++; $display("FAIL mid_level got=%0d want=3", fifo_level); end
    do_reset();
    total++;
    if (char_vld !== 1'b0 || char_data !== 8'h00 || done !== 1'b0 || exit_code !== 32'h0 ||
        drop_cnt !== 8'h00 || fifo_level !== 4'd0) begin
      bad++; $display("FAIL mid_reset got vld=%0h data=%0h done=%0h code=%0h drop=%0d level=%0d want all 0",
                      char_vld, char_data, done, exit_code, drop_cnt, fifo_level);
    end
    wr(CMD, PUTC);
    total++; if (drop_cnt !== 8'd1 || fifo_level !== 4'd0) begin bad++; $display("FAIL mid_orphan got drop=%0d level=%0d want 1/0", drop_cnt, fifo_level); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 255; i++) wr(CMD, PUTC);
    total++; if (drop_cnt !== 8'hFF) begin bad++; $display("FAIL sat_reach got=%0h want=ff", drop_cnt); end
    for (int i = 0; i < 45; i++) wr(CMD, $urandom);
    total++; if (drop_cnt !== 8'hFF) begin bad++; $display("FAIL sat_hold got=%0h want=ff", drop_cnt); end
  endtask

  task automatic test_random();
    int sel;
    logic [7:0] exp_data;
    int errs;
    do_reset();
    errs = 0;
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 399) == 0);
      cs       = ($urandom_range(0, 3) != 0);
      we       = ($urandom_range(0, 3) != 0);
      char_rdy = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        a = ARG; di = $urandom;
      end else if (sel < 8) begin
        a = CMD;
        sel = $urandom_range(0, 199);
        di = (sel == 0) ? EXIT : (sel < 150) ? PUTC : $urandom;
      end else begin
        a = 14'($urandom); di = $urandom;
      end
      tick();
      exp_data = (m_q.size() > 0) ? m_q[0] : m_last;
      total++;
      if (char_vld !== (m_q.size() > 0) || char_data !== exp_data || fifo_level !== 4'(m_q.size()) ||
          done !== m_done || exit_code !== m_exit || drop_cnt !== 8'(m_drop)) begin
        bad++;
        if (errs < 10)
          $display("FAIL rand_c%0d got vld=%0h data=%0h lvl=%0d done=%0h code=%0h drop=%0d want vld=%0h data=%0h lvl=%0d done=%0h code=%0h drop=%0d",
                   c, char_vld, char_data, fifo_level, done, exit_code, drop_cnt,
                   (m_q.size() > 0), exp_data, m_q.size(), m_done, m_exit, m_drop);
        errs++;
      end
    end
    rst = 1'b0; cs = 1'b0; we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; we = 1'b0; a = '0; di = '0; char_rdy = 1'b0;
    test_reset();
    test_putc_single();
    test_fifo_full();
    test_orphan();
    test_exit();
    test_rst_mid();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
